// File: rtl/defunnel_gearbox.sv
// Packs 1/2/4-lane input beats into wide CHUNKS-chunk words with per-chunk enables.
// Define DEFUNNEL_GEARBOX_SKID_EN to give the accumulator its own output register.
module defunnel_gearbox #(
  parameter int CHUNK_W = 128,
  parameter int CHUNKS  = 8,
  parameter int LANES   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      t_req,
  output logic                      t_ack,
  input  logic [LANES*CHUNK_W-1:0]  t_data,
  input  logic                      t_last,
  input  logic [7:0]                mode,
  output logic                      i_req,
  input  logic                      i_ack,
  output logic [CHUNKS*CHUNK_W-1:0] i_data,
  output logic [CHUNKS-1:0]         i_enable,
  output logic                      i_last,
  output logic                      cfg_err,
  output logic [15:0]               words
);
  localparam int PTR_W = $clog2(CHUNKS) + 1;
  localparam int LOG_W = $clog2(LANES) + 1;

  typedef logic [CHUNKS-1:0][CHUNK_W-1:0] word_t;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [LOG_W-1:0]  lanesLog_q, lanesLog_d;
  logic              ready_q;
  logic              cfgErr_q, cfgErr_d;
  logic [15:0]       words_q, words_d;
  word_t             outData_q, outData_d;
  logic [CHUNKS-1:0] outEn_q, outEn_d;
  logic              outLast_q, outLast_d;
  logic              outValid_q, outValid_d;
`ifdef DEFUNNEL_GEARBOX_SKID_EN
  word_t             accData_q, accData_d;
  logic [CHUNKS-1:0] accEn_q, accEn_d;
  logic              accLast_q, accLast_d;
  logic              accFull_q, accFull_d;
`endif

  logic              modeLegal;
  logic [LOG_W-1:0]  modeLog;
  logic              ptrAtZero;
  logic [LOG_W-1:0]  curLog;
  logic [PTR_W-1:0]  curLanes;
  logic              canAccept, xfer, outXfer, closing;
  word_t             baseData, mergeData;
  logic [CHUNKS-1:0] baseEn, mergeEn;

  // Only an exact one-hot selecting at most LANES lanes is a usable mode.
  always_comb begin
    modeLegal = 1'b0;
    modeLog   = '0;
    for (int n = 0; n < 8; n++) begin
      if (mode == 8'(1 << n) && n <= $clog2(LANES)) begin
        modeLegal = 1'b1;
        modeLog   = LOG_W'(n);
      end
    end
  end

  assign ptrAtZero = (ptr_q == '0);
  assign curLog    = ptrAtZero ? modeLog : lanesLog_q;
  assign curLanes  = PTR_W'(1) << curLog;

`ifdef DEFUNNEL_GEARBOX_SKID_EN
  assign canAccept = !accFull_q;
  assign baseData  = accData_q;
  assign baseEn    = accEn_q;
`else
  assign canAccept = !outValid_q;
  assign baseData  = outData_q;
  assign baseEn    = outEn_q;
`endif

  assign t_ack   = ready_q && canAccept && (!ptrAtZero || modeLegal);
  assign xfer    = t_req && t_ack;
  assign outXfer = outValid_q && i_ack;
  assign closing = xfer && ((ptr_q + curLanes == PTR_W'(CHUNKS)) || t_last);

  // ptr is always a multiple of the latched lane count, so lanes never wrap past the word.
  always_comb begin
    mergeData = baseData;
    mergeEn   = baseEn;
    for (int k = 0; k < LANES; k++) begin
      for (int c = 0; c < CHUNKS; c++) begin
        if (xfer && k < int'(curLanes) && c == int'(ptr_q) + k) begin
          mergeData[c] = t_data[k*CHUNK_W +: CHUNK_W];
          mergeEn[c]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    lanesLog_d = lanesLog_q;
    cfgErr_d   = cfgErr_q | (ptrAtZero & !modeLegal);
    words_d    = outXfer ? words_q + 16'd1 : words_q;
    outData_d  = outData_q;
    outEn_d    = outEn_q;
    outLast_d  = outLast_q;
    outValid_d = outValid_q;
    if (xfer) begin
      ptr_d = closing ? '0 : ptr_q + curLanes;
      if (ptrAtZero) lanesLog_d = modeLog;
    end
`ifdef DEFUNNEL_GEARBOX_SKID_EN
    accData_d = accData_q;
    accEn_d   = accEn_q;
    accLast_d = accLast_q;
    accFull_d = accFull_q;
    if (outXfer) outValid_d = 1'b0;
    // A parked word has priority; it blocks input until the output register frees up.
    if (accFull_q) begin
      if (!outValid_q || i_ack) begin
        outData_d  = accData_q;
        outEn_d    = accEn_q;
        outLast_d  = accLast_q;
        outValid_d = 1'b1;
        accData_d  = '0;
        accEn_d    = '0;
        accLast_d  = 1'b0;
        accFull_d  = 1'b0;
      end
    end else if (xfer) begin
      if (closing && (!outValid_q || i_ack)) begin
        outData_d  = mergeData;
        outEn_d    = mergeEn;
        outLast_d  = t_last;
        outValid_d = 1'b1;
        accData_d  = '0;
        accEn_d    = '0;
        accLast_d  = 1'b0;
      end else begin
        accData_d = mergeData;
        accEn_d   = mergeEn;
        accLast_d = t_last;
        accFull_d = closing;
      end
    end
`else
    if (outXfer) begin
      outData_d  = '0;
      outEn_d    = '0;
      outLast_d  = 1'b0;
      outValid_d = 1'b0;
    end else if (xfer) begin
      outData_d  = mergeData;
      outEn_d    = mergeEn;
      outLast_d  = closing && t_last;
      outValid_d = closing;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      lanesLog_q <= '0;
      ready_q    <= 1'b0;
      cfgErr_q   <= 1'b0;
      words_q    <= '0;
      outData_q  <= '0;
      outEn_q    <= '0;
      outLast_q  <= 1'b0;
      outValid_q <= 1'b0;
`ifdef DEFUNNEL_GEARBOX_SKID_EN
      accData_q  <= '0;
      accEn_q    <= '0;
      accLast_q  <= 1'b0;
      accFull_q  <= 1'b0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      lanesLog_q <= lanesLog_d;
      ready_q    <= 1'b1;
      cfgErr_q   <= cfgErr_d;
      words_q    <= words_d;
      outData_q  <= outData_d;
      outEn_q    <= outEn_d;
      outLast_q  <= outLast_d;
      outValid_q <= outValid_d;
`ifdef DEFUNNEL_GEARBOX_SKID_EN
      accData_q  <= accData_d;
      accEn_q    <= accEn_d;
      accLast_q  <= accLast_d;
      accFull_q  <= accFull_d;
`endif
    end
  end

  assign i_req    = outValid_q;
  assign i_data   = outData_q;
  assign i_enable = outEn_q;
  assign i_last   = outLast_q;
  assign cfg_err  = cfgErr_q;
  assign words    = words_q;

endmodule

// File: tb/tb_defunnel_gearbox.sv
// Directed scoreboard bench for defunnel_gearbox (CHUNKS=8, LANES=4, CHUNK_W=128).
module tb_defunnel_gearbox;
  localparam int CHUNK_W = 128;
  localparam int CHUNKS  = 8;
  localparam int LANES   = 4;
  localparam int GARB    = 32'hBAD0;

  typedef struct {
    logic [CHUNKS-1:0][CHUNK_W-1:0] data;
    logic [CHUNKS-1:0]              en;
    logic                           last;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      t_req;
  logic                      t_ack;
  logic [LANES*CHUNK_W-1:0]  t_data;
  logic                      t_last;
  logic [7:0]                mode;
  logic                      i_req;
  logic                      i_ack;
  logic [CHUNKS*CHUNK_W-1:0] i_data;
  logic [CHUNKS-1:0]         i_enable;
  logic                      i_last;
  logic                      cfg_err;
  logic [15:0]               words;

  int   checkCount = 0;
  int   passCount  = 0;
  int   expWords   = 0;
  exp_t expQ[$];
  exp_t popped;

  defunnel_gearbox #(.CHUNK_W(CHUNK_W), .CHUNKS(CHUNKS), .LANES(LANES)) dut (
    .clk(clk), .reset_n(reset_n), .t_req(t_req), .t_ack(t_ack), .t_data(t_data),
    .t_last(t_last), .mode(mode), .i_req(i_req), .i_ack(i_ack), .i_data(i_data),
    .i_enable(i_enable), .i_last(i_last), .cfg_err(cfg_err), .words(words)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [LANES*CHUNK_W-1:0] mkBeat(input int l0, input int l1, input int l2, input int l3);
    mkBeat = {CHUNK_W'(l3), CHUNK_W'(l2), CHUNK_W'(l1), CHUNK_W'(l0)};
  endfunction

  // Word whose first n chunks hold base, base+1, ... and the rest are zero.
  function automatic exp_t mkWord(input int base, input int n, input logic [CHUNKS-1:0] en, input logic last);
    exp_t w;
    for (int c = 0; c < CHUNKS; c++) w.data[c] = (c < n) ? CHUNK_W'(base + c) : '0;
    w.en   = en;
    w.last = last;
    return w;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic applyStimulus(input logic [LANES*CHUNK_W-1:0] d, input logic [7:0] m, input logic l);
    bit done = 0;
    t_req  = 1'b1;
    t_data = d;
    mode   = m;
    t_last = l;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      done = t_ack;
      @(posedge clk);
      #1;
    end
    t_req  = 1'b0;
    t_last = 1'b0;
    if (!done) checkOutput("beat accept timeout", 128'(0), 128'(1));
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 128'(expQ.size()), 128'(0));
  endtask

  always @(negedge clk) begin
    if (!reset_n) expWords = 0;
    else if (i_req && i_ack) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected word: got words=%0d, expected no word", words);
      end else begin
        popped = expQ.pop_front();
        for (int c = 0; c < CHUNKS; c++)
          checkOutput($sformatf("word%0d chunk%0d", expWords, c), i_data[c*CHUNK_W +: CHUNK_W], popped.data[c]);
        checkOutput($sformatf("word%0d i_enable", expWords), 128'(i_enable), 128'(popped.en));
        checkOutput($sformatf("word%0d i_last", expWords), 128'(i_last), 128'(popped.last));
      end
      checkOutput($sformatf("word%0d words counter", expWords), 128'(words), 128'(expWords));
      expWords++;
    end
  end

  initial begin
    int accepted;
    bit lastAck;
    int expAccepted;
    reset_n = 1'b0;
    t_req   = 1'b0;
    t_data  = '0;
    t_last  = 1'b0;
    mode    = 8'h01;
    i_ack   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset t_ack", 128'(t_ack), 128'(0));
    checkOutput("reset i_req", 128'(i_req), 128'(0));
    checkOutput("reset i_enable", 128'(i_enable), 128'(0));
    checkOutput("reset i_last", 128'(i_last), 128'(0));
    checkOutput("reset i_data any bit", 128'(|i_data), 128'(0));
    checkOutput("reset cfg_err", 128'(cfg_err), 128'(0));
    checkOutput("reset words", 128'(words), 128'(0));
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single-lane beats fill all eight chunks in order.
    expQ.push_back(mkWord(0, 8, 8'hFF, 1'b0));
    for (int k = 0; k < 8; k++) applyStimulus(mkBeat(k, GARB, GARB, GARB), 8'h01, 1'b0);
    waitDrain();
    checkOutput("words after first word", 128'(words), 128'(1));

    // Four-lane word, then a two-lane word that must start back at chunk 0.
    expQ.push_back(mkWord(10, 8, 8'hFF, 1'b0));
    applyStimulus(mkBeat(10, 11, 12, 13), 8'h04, 1'b0);
    applyStimulus(mkBeat(14, 15, 16, 17), 8'h04, 1'b0);
    expQ.push_back(mkWord(20, 8, 8'hFF, 1'b0));
    for (int b = 0; b < 4; b++) applyStimulus(mkBeat(20 + 2*b, 21 + 2*b, GARB, GARB), 8'h02, 1'b0);

    // t_last flushes partial words; unwritten chunks must read zero.
    expQ.push_back(mkWord(30, 2, 8'h03, 1'b1));
    applyStimulus(mkBeat(30, 31, GARB, GARB), 8'h02, 1'b1);
    expQ.push_back(mkWord(40, 3, 8'h07, 1'b1));
    applyStimulus(mkBeat(40, GARB, GARB, GARB), 8'h01, 1'b0);
    applyStimulus(mkBeat(41, GARB, GARB, GARB), 8'h01, 1'b0);
    applyStimulus(mkBeat(42, GARB, GARB, GARB), 8'h01, 1'b1);
    waitDrain();

    // Output stalled with continuous input.
`ifdef DEFUNNEL_GEARBOX_SKID_EN
    expAccepted = 4;
    expQ.push_back(mkWord(50, 8, 8'hFF, 1'b0));
    expQ.push_back(mkWord(60, 8, 8'hFF, 1'b0));
`else
    expAccepted = 2;
    expQ.push_back(mkWord(50, 8, 8'hFF, 1'b0));
`endif
    i_ack    = 1'b0;
    mode     = 8'h04;
    accepted = 0;
    lastAck  = 1'b1;
    t_req    = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      t_data = mkBeat(50 + 10*(accepted/2) + 4*(accepted%2), 51 + 10*(accepted/2) + 4*(accepted%2),
                      52 + 10*(accepted/2) + 4*(accepted%2), 53 + 10*(accepted/2) + 4*(accepted%2));
      @(negedge clk);
      lastAck = t_ack;
      if (t_ack) accepted++;
      @(posedge clk);
      #1;
    end
    t_req = 1'b0;
    checkOutput("stall accepted beats", 128'(accepted), 128'(expAccepted));
    checkOutput("stall t_ack low", 128'(lastAck), 128'(0));
    checkOutput("stall i_req held", 128'(i_req), 128'(1));
    i_ack = 1'b1;
    waitDrain();

    // Illegal modes block input and latch cfg_err until reset.
    mode = 8'h03;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("mode 0x03 t_ack", 128'(t_ack), 128'(0));
    checkOutput("mode 0x03 cfg_err", 128'(cfg_err), 128'(1));
    mode = 8'h01;
    @(posedge clk);
    #1;
    checkOutput("legal mode after error cfg_err", 128'(cfg_err), 128'(1));
    checkOutput("legal mode after error t_ack", 128'(t_ack), 128'(1));
    mode = 8'h08;
    @(posedge clk);
    #1;
    checkOutput("mode 0x08 t_ack", 128'(t_ack), 128'(0));
    mode    = 8'h01;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cfg_err cleared by reset", 128'(cfg_err), 128'(0));
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-word drops the partial word.
    for (int k = 0; k < 3; k++) applyStimulus(mkBeat(70 + k, GARB, GARB, GARB), 8'h01, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid-word reset i_req", 128'(i_req), 128'(0));
    checkOutput("mid-word reset words", 128'(words), 128'(0));
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("after reset i_req", 128'(i_req), 128'(0));
    checkOutput("after reset words", 128'(words), 128'(0));
    expQ.push_back(mkWord(80, 8, 8'hFF, 1'b0));
    for (int k = 0; k < 8; k++) applyStimulus(mkBeat(80 + k, GARB, GARB, GARB), 8'h01, 1'b0);
    waitDrain();
    checkOutput("words after reset word", 128'(words), 128'(1));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
